// File: rtl/pc_stack_n.sv
// Program counter with a circular return-address stack and serial nibble emission.
// All state commits once per machine cycle, on the sub-cycle 7 edge, unless halted.
module pc_stack_n #(
  parameter  int ADDR_NIBBLES = 3,
  parameter  int DEPTH        = 3,
  localparam int AW           = 4 * ADDR_NIBBLES,
  localparam int LW           = $clog2(DEPTH + 1),
  localparam int PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          halt,
  input  logic [2:0]    cycle,
  input  logic [1:0]    control,
  input  logic          load,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] pc,
  output logic          pc_enable,
  output logic [3:0]    pc_word,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          underflow
);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) ptr_inc = PW'(0);
    else                     ptr_inc = p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    if (p == PW'(0)) ptr_dec = PW'(DEPTH - 1);
    else             ptr_dec = p - PW'(1);
  endfunction

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_stack [DEPTH];
  logic [PW-1:0] r_wp;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic          r_unf;

  logic          w_commit;
  logic [PW-1:0] w_top;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_nxt;
  logic [PW-1:0] w_wp_nxt;
  logic [LW-1:0] w_level_nxt;
  logic          w_ovf_nxt;
  logic          w_unf_nxt;
  logic          w_push;
  logic          w_en;
  logic [3:0]    w_word;

  assign w_commit = (cycle == 3'd7) && !halt;
  assign w_top    = ptr_dec(r_wp);
  assign w_pc_inc = r_pc + AW'(1);

  // Next-state decode for pc, stack pointer, level and sticky flags
  always_comb begin
    w_pc_nxt    = r_pc;
    w_wp_nxt    = r_wp;
    w_level_nxt = r_level;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    case (control)
      2'b00: begin
        if (load) w_pc_nxt = target;
        else      w_pc_nxt = r_pc;
      end
      2'b01: begin
        if (load) w_pc_nxt = target;
        else      w_pc_nxt = w_pc_inc;
      end
      2'b10: begin
        // A full stack overwrites its oldest slot, which is exactly where r_wp points.
        w_push   = 1'b1;
        w_pc_nxt = target;
        w_wp_nxt = ptr_inc(r_wp);
        if (r_level == LW'(DEPTH)) w_ovf_nxt   = 1'b1;
        else                       w_level_nxt = r_level + LW'(1);
      end
      2'b11: begin
        if (r_level == LW'(0)) begin
          w_unf_nxt = 1'b1;
          w_pc_nxt  = w_pc_inc;
        end else begin
          w_pc_nxt    = r_stack[w_top];
          w_wp_nxt    = w_top;
          w_level_nxt = r_level - LW'(1);
        end
      end
      default: begin
        w_pc_nxt = r_pc;
      end
    endcase
  end

  // Commit pc, pointer, level and flags at the end of each machine cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc    <= AW'(0);
      r_wp    <= PW'(0);
      r_level <= LW'(0);
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_commit) begin
      r_pc    <= w_pc_nxt;
      r_wp    <= w_wp_nxt;
      r_level <= w_level_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Return-address storage, written only on a committed call
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= AW'(0);
    end else if (w_commit && w_push) begin
      r_stack[r_wp] <= w_pc_inc;
    end
  end

  // Serial nibble emission straight from the registered pc, low nibble first
  always_comb begin
    w_en   = 1'b0;
    w_word = 4'h0;
    for (int k = 0; k < ADDR_NIBBLES; k++) begin
      if (cycle == 3'(k)) begin
        w_en   = 1'b1;
        w_word = r_pc[4*k +: 4];
      end else begin
        w_en   = w_en;
        w_word = w_word;
      end
    end
  end

  assign pc        = r_pc;
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign pc_enable = w_en;
  assign pc_word   = w_word;

endmodule

// File: tb/tb_pc_stack_n.sv
// Directed bench for pc_stack_n: a reference model pushes expected commit results
// to a scoreboard queue; they are popped and compared after each machine cycle.
module tb_pc_stack_n;

  typedef struct {
    logic [11:0] pc;
    logic [1:0]  lvl;
    logic        ov;
    logic        un;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, halt, load;
  logic [2:0]  cycle;
  logic [1:0]  control;
  logic [11:0] target, pc;
  logic        pc_enable, overflow, underflow;
  logic [3:0]  pc_word;
  logic [1:0]  level;

  logic        reset2;
  logic [1:0]  control2;
  logic        halt2 = 1'b0;
  logic        load2 = 1'b0;
  logic [15:0] target2 = 16'h0000;
  logic [15:0] pc2;
  logic        en2, ov2, un2;
  logic [3:0]  word2;
  logic [0:0]  level2;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t        sb[$];
  logic [11:0] m_pc;
  logic [11:0] m_stk[$];
  logic        m_ov, m_un;

  pc_stack_n #(.ADDR_NIBBLES(3), .DEPTH(3)) dut (
    .clock(clock), .reset(reset), .halt(halt), .cycle(cycle), .control(control),
    .load(load), .target(target), .pc(pc), .pc_enable(pc_enable), .pc_word(pc_word),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  pc_stack_n #(.ADDR_NIBBLES(4), .DEPTH(1)) dut2 (
    .clock(clock), .reset(reset2), .halt(halt2), .cycle(cycle), .control(control2),
    .load(load2), .target(target2), .pc(pc2), .pc_enable(en2), .pc_word(word2),
    .level(level2), .overflow(ov2), .underflow(un2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One machine cycle: model the commit, drive sub-cycles 0..7, then score the result.
  task automatic run_mc(input string name, input logic [1:0] ctl, input logic ld,
                        input logic [11:0] tgt, input logic hlt);
    logic [11:0] old;
    exp_t        e;
    old = m_pc;
    if (!hlt) begin
      case (ctl)
        2'b00: if (ld) m_pc = tgt;
        2'b01: m_pc = ld ? tgt : m_pc + 12'd1;
        2'b10: begin
          if (m_stk.size() == 3) begin
            void'(m_stk.pop_front());
            m_ov = 1'b1;
          end
          m_stk.push_back(m_pc + 12'd1);
          m_pc = tgt;
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_un = 1'b1;
            m_pc = m_pc + 12'd1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
      endcase
    end
    e.pc = m_pc; e.lvl = 2'(m_stk.size()); e.ov = m_ov; e.un = m_un;
    sb.push_back(e);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      cycle = 3'(c); control = ctl; load = ld; target = tgt; halt = hlt;
      #1;
      check($sformatf("%s en c%0d", name, c), {15'd0, pc_enable}, {15'd0, (c < 3)});
      check($sformatf("%s word c%0d", name, c), {12'd0, pc_word},
            (c < 3) ? {12'd0, old[4*c +: 4]} : 16'h0000);
    end
    @(negedge clock);
    cycle = 3'd0; control = 2'b00; load = 1'b0; halt = 1'b0;
    #1;
    e = sb.pop_front();
    check({name, " pc"},  {4'd0, pc},          {4'd0, e.pc});
    check({name, " lvl"}, {14'd0, level},      {14'd0, e.lvl});
    check({name, " ov"},  {15'd0, overflow},   {15'd0, e.ov});
    check({name, " un"},  {15'd0, underflow},  {15'd0, e.un});
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; halt = 1'b0; load = 1'b0;
    cycle = 3'd0; control = 2'b00; target = 12'h000; control2 = 2'b00;
    m_pc = 12'h000; m_ov = 1'b0; m_un = 1'b0;
    @(negedge clock); #1;
    check("rst pc",  {4'd0, pc},         16'h0000);
    check("rst lvl", {14'd0, level},     16'h0000);
    check("rst ov",  {15'd0, overflow},  16'h0000);
    check("rst un",  {15'd0, underflow}, 16'h0000);
    check("rst en",  {15'd0, pc_enable}, 16'h0001);
    reset = 1'b0;

    run_mc("inc1", 2'b01, 1'b0, 12'h000, 1'b0);
    run_mc("inc2", 2'b01, 1'b0, 12'h000, 1'b0);
    run_mc("jmpfff", 2'b00, 1'b1, 12'hFFF, 1'b0);
    run_mc("wrap", 2'b01, 1'b0, 12'h000, 1'b0);
    run_mc("jmp010", 2'b01, 1'b1, 12'h010, 1'b0);
    run_mc("call200", 2'b10, 1'b1, 12'h200, 1'b0);
    run_mc("ret011", 2'b11, 1'b1, 12'h000, 1'b0);
    run_mc("hold", 2'b00, 1'b0, 12'h000, 1'b0);

    run_mc("jmp001", 2'b00, 1'b1, 12'h001, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      run_mc($sformatf("call%0d", i), 2'b10, 1'b0, 12'(i * 256), 1'b0);
      if (i < 4) run_mc($sformatf("inc%0d", i), 2'b01, 1'b0, 12'h000, 1'b0);
    end
    for (int i = 1; i <= 4; i++) run_mc($sformatf("ret%0d", i), 2'b11, 1'b0, 12'h000, 1'b0);

    run_mc("halted", 2'b01, 1'b0, 12'h000, 1'b1);
    run_mc("callA", 2'b10, 1'b0, 12'h500, 1'b0);
    run_mc("callB", 2'b10, 1'b0, 12'h600, 1'b0);

    // Asynchronous reset in the middle of a machine cycle
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      cycle = 3'(c);
    end
    reset = 1'b1;
    #1;
    check("mrst pc",   {4'd0, pc},         16'h0000);
    check("mrst lvl",  {14'd0, level},     16'h0000);
    check("mrst ov",   {15'd0, overflow},  16'h0000);
    check("mrst un",   {15'd0, underflow}, 16'h0000);
    check("mrst en",   {15'd0, pc_enable}, 16'h0000);
    check("mrst word", {12'd0, pc_word},   16'h0000);
    @(negedge clock);
    cycle = 3'd0;
    #1;
    check("mrst en0", {15'd0, pc_enable}, 16'h0001);
    reset = 1'b0;
    m_pc = 12'h000; m_stk.delete(); m_ov = 1'b0; m_un = 1'b0;
    run_mc("post", 2'b01, 1'b0, 12'h000, 1'b0);

    // Wider, single-entry configuration
    @(negedge clock);
    reset2 = 1'b0; control2 = 2'b01;
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        cycle = 3'(c);
      end
    end
    @(negedge clock);
    cycle = 3'd0; control2 = 2'b00;
    #1;
    check("w16 pc",  pc2,             16'h0002);
    check("w16 lvl", {15'd0, level2}, 16'h0000);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      cycle = 3'(c);
      #1;
      check($sformatf("w16 en c%0d", c), {15'd0, en2}, {15'd0, (c < 4)});
      check($sformatf("w16 word c%0d", c), {12'd0, word2}, (c == 0) ? 16'h0002 : 16'h0000);
    end
    @(negedge clock);
    cycle = 3'd0;
    check("sb empty", 16'(sb.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
